// File: rtl/flash_ctrl.sv
// Parallel NOR flash controller: 32-bit CPU reads as two 16-bit flash reads,
// 16-bit flash write cycles, and a self-timed ready handshake.
module flash_ctrl #(
  parameter int T_READ = 5,
  parameter int T_WE   = 4,
  parameter int T_HOLD = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        select,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic [24:0] fl_addr,
  input  logic [15:0] fl_dq_in,
  output logic [15:0] fl_dq_out,
  output logic        fl_dq_oe,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  output logic        fl_we_n,
  output logic        fl_rst_n
);

  localparam int TM1  = (T_READ > T_WE) ? T_READ : T_WE;
  localparam int TMAX = (TM1 > T_HOLD) ? TM1 : T_HOLD;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [24:0] addr_q, addr_src;
  logic [15:0] wdata_q, wdata_src;
  logic [1:0] rst_sync;
  logic req, last;
  logic unused;

  assign unused = ^{address[31:26], address[0], data_in[31:16]};

  assign req  = select & (read | write);
  assign last = (cnt == CW'(1));

  // The first phase latches straight from the bus; later phases use the copy.
  assign addr_src  = (state == IDLE) ? address[25:1] : addr_q;
  assign wdata_src = (state == IDLE) ? data_in[15:0] : wdata_q;

  // Next-state and phase counter.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req & read) begin
          state_d = RD_HI;
          cnt_d   = CW'(T_READ);
        end else if (req) begin
          state_d = WR_SETUP;
        end
      end
      RD_HI: begin
        if (last) begin
          state_d = RD_LO;
          cnt_d   = CW'(T_READ);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RD_LO: begin
        if (last) state_d = DONE;
        else cnt_d = cnt - 1'b1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CW'(T_WE);
      end
      WR_PULSE: begin
        if (last) begin
          state_d = WR_HOLD;
          cnt_d   = CW'(T_HOLD);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WR_HOLD: begin
        if (last) state_d = DONE;
        else cnt_d = cnt - 1'b1;
      end
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Capture the request's address and write data once, in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      addr_q  <= address[25:1];
      wdata_q <= data_in[15:0];
    end
  end

  // Assemble read data big-endian at the end of each half.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (state == RD_HI && last) begin
      data_out[31:16] <= fl_dq_in;
    end else if (state == RD_LO && last) begin
      data_out[15:0] <= fl_dq_in;
    end
  end

  // Registered flash strobes, bus and ready, decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready     <= 1'b0;
      fl_addr   <= '0;
      fl_dq_out <= '0;
      fl_dq_oe  <= 1'b0;
      fl_ce_n   <= 1'b1;
      fl_oe_n   <= 1'b1;
      fl_we_n   <= 1'b1;
    end else begin
      ready    <= (state_d == DONE);
      fl_ce_n  <= (state_d == IDLE) || (state_d == DONE);
      fl_oe_n  <= !((state_d == RD_HI) || (state_d == RD_LO));
      fl_we_n  <= (state_d != WR_PULSE);
      fl_dq_oe <= (state_d == WR_SETUP) || (state_d == WR_PULSE) ||
                  (state_d == WR_HOLD);
      if (state_d == RD_HI) fl_addr <= {addr_src[24:1], 1'b0};
      if (state_d == RD_LO) fl_addr <= {addr_src[24:1], 1'b1};
      if (state_d == WR_SETUP) begin
        fl_addr   <= addr_src;
        fl_dq_out <= wdata_src;
      end
    end
  end

  // Flash reset released two edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end

  assign fl_rst_n = rst_sync[1];

endmodule

// File: tb/tb_flash_ctrl.sv
// Scoreboarded bench for flash_ctrl: directed accesses, ready/latency/data
// checked by a monitor, strobe shapes checked inline.
module tb_flash_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        select = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        ready;
  logic [24:0] fl_addr;
  logic [15:0] fl_dq_in;
  logic [15:0] fl_dq_out;
  logic        fl_dq_oe;
  logic        fl_ce_n;
  logic        fl_oe_n;
  logic        fl_we_n;
  logic        fl_rst_n;

  flash_ctrl dut (
    .clock(clock), .reset_n(reset_n), .select(select),
    .read(read), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .ready(ready),
    .fl_addr(fl_addr), .fl_dq_in(fl_dq_in), .fl_dq_out(fl_dq_out),
    .fl_dq_oe(fl_dq_oe), .fl_ce_n(fl_ce_n), .fl_oe_n(fl_oe_n),
    .fl_we_n(fl_we_n), .fl_rst_n(fl_rst_n)
  );

  always #5 clock = ~clock;

  // Flash contents: two fixed words, everything else addr ^ 5A5A.
  always_comb begin
    if (fl_addr == 25'h8) fl_dq_in = 16'h1234;
    else if (fl_addr == 25'h9) fl_dq_in = 16'hABCD;
    else fl_dq_in = fl_addr[15:0] ^ 16'h5A5A;
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each rising ready retires one expected access.
  logic rdy_q = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      rdy_q = 1'b0;
    end else begin
      if (ready && !rdy_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
          chk("data_out", data_out, e.data);
        end
      end
      rdy_q = ready;
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input bit push,
                       input logic [31:0] exp_data, input int lat);
    exp_t e;
    @(negedge clock);
    if (push) begin
      e.data  = exp_data;
      e.lat   = lat;
      e.start = cyc + 1;
      sb.push_back(e);
    end
    select  = 1'b1;
    read    = rd;
    write   = wr;
    address = a;
    data_in = d;
  endtask

  task automatic watch(input int drop_k, input logic [31:0] new_addr,
                       output int ce_lo, output int oe_lo, output int we_lo,
                       output int we_first, output logic [24:0] wa,
                       output logic [15:0] wd, output logic woe);
    int rk;
    rk = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; we_first = 0;
    wa = '0; wd = '0; woe = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == drop_k) begin
        read = 1'b0;
        write = 1'b0;
        address = new_addr;
      end
      if (!fl_ce_n) ce_lo++;
      if (!fl_oe_n) oe_lo++;
      if (!fl_we_n) begin
        we_lo++;
        if (we_first == 0) begin
          we_first = k;
          wa = fl_addr;
          wd = fl_dq_out;
          woe = fl_dq_oe;
        end
      end
      if (ready) begin
        rk = k;
        break;
      end
    end
    if (rk == 0) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  int ce_lo, oe_lo, we_lo, we_first, n_ce, n_rdy;
  logic [24:0] wa;
  logic [15:0] wd;
  logic woe;

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_strobes", {29'd0, fl_ce_n, fl_oe_n, fl_we_n}, 32'd7);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_fl_rst_n", {31'd0, fl_rst_n}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("fl_rst_n_edge1", {31'd0, fl_rst_n}, 32'd0);
    @(negedge clock);
    chk("fl_rst_n_edge2", {31'd0, fl_rst_n}, 32'd1);

    // Read 0xE0000010 -> halfwords 8,9; hold request after ready.
    issue(1'b1, 1'b0, 32'hE000_0010, 32'd0, 1'b1, 32'h1234_ABCD, 10);
    watch(0, 32'd0, ce_lo, oe_lo, we_lo, we_first, wa, wd, woe);
    chk("rd_oe_low_cycles", 32'(oe_lo), 32'd10);
    n_ce = 0; n_rdy = 0;
    repeat (3) begin
      @(negedge clock);
      if (!fl_ce_n) n_ce++;
      if (ready) n_rdy++;
    end
    chk("hold_ready_high", 32'(n_rdy), 32'd3);
    chk("hold_no_flash", 32'(n_ce), 32'd0);
    read = 1'b0;
    @(negedge clock);
    chk("drop_ready_low", {31'd0, ready}, 32'd0);

    // Fresh read at 0x100 -> halfwords 0x80,0x81.
    issue(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'h5ADA_5ADB, 10);
    watch(0, 32'd0, ce_lo, oe_lo, we_lo, we_first, wa, wd, woe);
    chk("rd2_oe_low_cycles", 32'(oe_lo), 32'd10);
    read = 1'b0;
    @(negedge clock);

    // Write 0xAA at 0xE0000AAA; data_out must keep last read value.
    issue(1'b0, 1'b1, 32'hE000_0AAA, 32'h0000_00AA, 1'b1, 32'h5ADA_5ADB, 6);
    watch(0, 32'd0, ce_lo, oe_lo, we_lo, we_first, wa, wd, woe);
    chk("wr_we_low_cycles", 32'(we_lo), 32'd4);
    chk("wr_ce_low_cycles", 32'(ce_lo), 32'd6);
    chk("wr_we_first", 32'(we_first), 32'd2);
    chk("wr_fl_addr", {7'd0, wa}, 32'h0000_0555);
    chk("wr_fl_dq_out", {16'd0, wd}, 32'h0000_00AA);
    chk("wr_dq_oe", {31'd0, woe}, 32'd1);
    chk("wr_no_oe", 32'(oe_lo), 32'd0);
    write = 1'b0;
    @(negedge clock);
    chk("wr_drop_ready_low", {31'd0, ready}, 32'd0);

    // Abort: drop read and move address at cycle 3; both halves complete.
    issue(1'b1, 1'b0, 32'h0000_0200, 32'd0, 1'b1, 32'h5B5A_5B5B, 10);
    watch(3, 32'hFFFF_FFFC, ce_lo, oe_lo, we_lo, we_first, wa, wd, woe);
    chk("abort_oe_low_cycles", 32'(oe_lo), 32'd10);
    @(negedge clock);
    chk("abort_done_one_cycle", {31'd0, ready}, 32'd0);

    // Not selected: no flash activity.
    select = 1'b0;
    read = 1'b1;
    n_ce = 0; n_rdy = 0;
    repeat (12) begin
      @(negedge clock);
      if (!fl_ce_n) n_ce++;
      if (ready) n_rdy++;
    end
    chk("nosel_no_flash", 32'(n_ce), 32'd0);
    chk("nosel_no_ready", 32'(n_rdy), 32'd0);
    read = 1'b0;

    // Read and write together is a read.
    issue(1'b1, 1'b1, 32'h0000_0010, 32'h0000_FFFF, 1'b1, 32'h1234_ABCD, 10);
    watch(0, 32'd0, ce_lo, oe_lo, we_lo, we_first, wa, wd, woe);
    chk("rdwr_no_we", 32'(we_lo), 32'd0);
    read = 1'b0;
    write = 1'b0;
    @(negedge clock);

    // Reset in the middle of the write pulse.
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0055, 1'b0, 32'd0, 0);
    repeat (3) @(negedge clock);
    chk("midwr_we_low", {31'd0, fl_we_n}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("midwr_we_released", {31'd0, fl_we_n}, 32'd1);
    chk("midwr_ce_released", {31'd0, fl_ce_n}, 32'd1);
    chk("midwr_data_cleared", data_out, 32'd0);
    write = 1'b0;
    select = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("postrst_idle", {30'd0, ready, fl_ce_n}, 32'd1);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 32'h1234_ABCD, 10);
    watch(0, 32'd0, ce_lo, oe_lo, we_lo, we_first, wa, wd, woe);
    read = 1'b0;
    repeat (2) @(negedge clock);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_ctrl.md
Name: flash_ctrl

Overview:
- Off-chip parallel NOR flash interface (32M x 16). Sits directly downstream of the address decoder; selected when the decoder's chip select equals 4'h8.
- Each 32-bit CPU read becomes two sequential 16-bit flash reads, assembled big-endian.
- CPU writes become single 16-bit flash write cycles, used for command/program sequences.
- Produces its own ready handshake, because flash timing is longer than the decoder's fixed bus cycle.

Parameters:
- T_READ, 5, clock cycles per 16-bit read access (address/OE valid to data sample); must be >=1
- T_WE, 4, clock cycles fl_we_n held low per write; must be >=1
- T_HOLD, 1, clock cycles address/data/CE held after fl_we_n rises; must be >=1

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- select  in  1  chip select decoded for flash (cs == 4'h8)
- read  in  1  bus read request
- write  in  1  bus write request
- address  in  32  CPU byte address; bits [25:1] used
- data_in  in  32  write data; bits [15:0] written
- data_out  out  32  assembled read data
- ready  out  1  access complete; held while request stays asserted
- fl_addr  out  25  flash halfword address
- fl_dq_in  in  16  flash data bus input
- fl_dq_out  out  16  flash data bus output
- fl_dq_oe  out  1  drive enable for fl_dq_out
- fl_ce_n  out  1  flash chip enable, active low
- fl_oe_n  out  1  flash output enable, active low
- fl_we_n  out  1  flash write enable, active low
- fl_rst_n  out  1  flash reset; follows reset_n through a 2-flop synchroniser (deasserts 2 edges after reset_n rises)

Behaviour:
- Reset values (asynchronous):
  - state IDLE; data_out 0; ready 0; fl_addr 0; fl_dq_out 0; fl_dq_oe 0
  - fl_ce_n, fl_oe_n, fl_we_n all 1; fl_rst_n 0
- Request: req = select & (read | write), sampled only in IDLE. If read and write are both high, the access is a read.
- States: IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A single down-counter, width $clog2 of the largest parameter + 1, times every phase.
- IDLE:
  - req & read -> RD_HI, counter = T_READ.
  - req & write -> WR_SETUP.
  - All flash strobes inactive.
- RD_HI:
  - fl_addr = {address[25:2],1'b0}; fl_ce_n = 0, fl_oe_n = 0.
  - Counter decrements each edge. On the edge where it reaches 1: data_out[31:16] <= fl_dq_in, counter = T_READ, -> RD_LO.
- RD_LO:
  - fl_addr = {address[25:2],1'b1}; CE/OE stay low with no glitch between halves.
  - On the count-1 edge: data_out[15:0] <= fl_dq_in, -> DONE.
- Read latency: ready is high 2*T_READ edges after the IDLE edge that sampled req (10 with defaults).
- WR_SETUP (1 cycle):
  - fl_addr = address[25:1]; fl_dq_out = data_in[15:0]; fl_dq_oe = 1; fl_ce_n = 0.
  - -> WR_PULSE, counter = T_WE.
- WR_PULSE: fl_we_n = 0 for exactly T_WE cycles, then -> WR_HOLD, counter = T_HOLD.
- WR_HOLD: fl_we_n = 1; CE, address and data still driven for T_HOLD cycles, then -> DONE.
- Write latency: 1+T_WE+T_HOLD edges (6 with defaults). data_out is unchanged by writes.
- DONE:
  - ready = 1, all flash strobes inactive, fl_dq_oe = 0.
  - Stay while (read|write) & select. Otherwise -> IDLE with ready low next cycle. This guarantees exactly one access per request.
- Outputs are registered: strobes, address and ready come from flops, never combinational from inputs.
- Request dropped mid-access: the current flash cycle still completes (no truncated WE or OE pulses). In DONE with no request, the block returns to IDLE the next edge.
- Address changing mid-access is ignored. fl_addr and fl_dq_out are latched at the start of each phase from the address and data sampled in IDLE.
- reset_n low mid-operation: all strobes return to inactive immediately and data_out clears to 0.

Test Plan:
- Reset then idle: reset_n low -> fl_ce_n/oe_n/we_n = 1, ready = 0, data_out = 0. After release, fl_rst_n rises after 2 edges.
- Read at address 0xE0000010:
  - Flash model returns 0x1234 at halfword 0x000008 and 0xABCD at 0x000009.
  - Required: data_out = 0x1234ABCD and ready high exactly 10 cycles after sampling.
  - fl_oe_n stays continuously low for 10 cycles.
- Write data_in = 0x000000AA at address 0xE0000AAA:
  - fl_addr = 0x000555 and fl_dq_out = 0x00AA.
  - fl_we_n low exactly 4 cycles, with CE low 1 cycle before and 1 cycle after.
  - ready high at cycle 6.
- Hold request after ready:
  - ready stays high and no second flash cycle starts.
  - Drop read -> ready low the next cycle, then a new read starts a fresh 10-cycle access.
- Abort: drop read at cycle 3 of RD_HI -> both halves still complete, DONE lasts 1 cycle, then IDLE. Select low with read high -> no flash activity.
- Reset mid-write: reset_n low during WR_PULSE -> fl_we_n returns to 1 asynchronously and state is IDLE after release.
